// File: rtl/irq_pkg.sv
// Shared constants and types for the 68000 vblank interrupt controller.
package irq_pkg;

  // Function code the 68000 drives during an interrupt acknowledge cycle.
  localparam logic [2:0] FC_IACK = 3'b111;

  // Inactive (all-high) interrupt priority lines.
  localparam logic [2:0] IPL_NONE = 3'b111;

  // Priority level raised on vblank unless overridden.
  localparam int IRQ_LEVEL_DEFAULT = 4;

  // Autovector handshake state.
  typedef enum logic {
    VPA_IDLE = 1'b0,
    VPA_ACK  = 1'b1
  } vpa_state_e;

endpackage

// File: rtl/m68k_irq_ctrl_if.sv
// 68000 bus-side signals seen by the interrupt controller.
//
// Handshake: the CPU holds cpu_as_n low for the whole bus cycle. During a
// matching IACK the controller answers by pulling vpa_n low (registered, one
// cycle after acceptance) and holds it low until the CPU releases cpu_as_n;
// vpa_n rises on the first clock edge that samples cpu_as_n high.
interface m68k_irq_ctrl_if;
  logic        int_en_cs;
  logic        vblank_cs;
  logic        cpu_rw;
  logic        cpu_lds_n;
  logic        cpu_as_n;
  logic [2:0]  cpu_fc;
  logic [2:0]  cpu_a;
  logic [15:0] cpu_dout;
  logic [15:0] irq_dout;
  logic        vpa_n;

  modport master (
    output int_en_cs, vblank_cs, cpu_rw, cpu_lds_n, cpu_as_n,
    output cpu_fc, cpu_a, cpu_dout,
    input  irq_dout, vpa_n
  );

  modport slave (
    input  int_en_cs, vblank_cs, cpu_rw, cpu_lds_n, cpu_as_n,
    input  cpu_fc, cpu_a, cpu_dout,
    output irq_dout, vpa_n
  );
endinterface

// File: rtl/edge_detect.sv
// Rising-edge detector. The arm flag keeps a level that is already high when
// reset releases from being reported as an edge: the delayed copy is reloaded
// during the first post-reset cycle before detection is enabled.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic d_q;
  logic armed_q;

  // Delay line and arm flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_i;
      armed_q <= 1'b1;
    end
  end

  assign q_o    = d_q;
  assign rise_o = d_i & ~d_q & armed_q;

endmodule

// File: rtl/m68k_irq_ctrl.sv
// Vblank interrupt and status controller for the 68000: interrupt enable
// register, pending flag, autovector handshake, status read and frame pulse.
module m68k_irq_ctrl
  import irq_pkg::*;
#(
  parameter int IRQ_LEVEL = IRQ_LEVEL_DEFAULT,
  parameter int VBL_BIT   = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 vblank,
  m68k_irq_ctrl_if.slave       bus,
  output logic [2:0]           ipl_n,
  output logic                 int_en,
  output logic                 frame_start,
  output vpa_state_e           dbg_vpa_state
);

  localparam logic [2:0] LEVEL = 3'(IRQ_LEVEL);

  logic       vblank_q;
  logic       vbl_rise;
  logic       int_en_q, int_en_d;
  logic       pending_q, pending_d;
  logic       frame_start_q;
  vpa_state_e vpa_state_q, vpa_state_d;
  logic       wr_en;
  logic       eff_en;
  logic       iack;
  logic       accept;
  logic [15:0] rd_data;
  logic       unused_dout;

  edge_detect u_vbl_edge (
    .clk_i  (clk_sys),
    .rst_i  (reset),
    .d_i    (vblank),
    .q_o    (vblank_q),
    .rise_o (vbl_rise)
  );

  assign wr_en  = bus.int_en_cs & ~bus.cpu_rw & ~bus.cpu_lds_n & ~bus.cpu_as_n;
  assign eff_en = wr_en ? bus.cpu_dout[0] : int_en_q;
  assign iack   = (bus.cpu_fc == FC_IACK) & ~bus.cpu_as_n & (bus.cpu_a == LEVEL);
  // Only an outstanding request is acknowledged; vpa_n already low means the
  // current IACK was accepted on an earlier edge.
  assign accept = iack & pending_q & (vpa_state_q == VPA_IDLE);

  // Next-state for enable, pending and the autovector handshake.
  always_comb begin
    int_en_d    = int_en_q;
    pending_d   = pending_q;
    vpa_state_d = vpa_state_q;

    if (wr_en) int_en_d = bus.cpu_dout[0];

    // Clears first, set last: a new frame wins over acceptance, while a
    // disable write wins over the frame because eff_en is then 0.
    if (accept) pending_d = 1'b0;
    if (wr_en && !bus.cpu_dout[0]) pending_d = 1'b0;
    if (vbl_rise && eff_en) pending_d = 1'b1;

    case (vpa_state_q)
      VPA_IDLE: if (accept) vpa_state_d = VPA_ACK;
      VPA_ACK:  if (bus.cpu_as_n) vpa_state_d = VPA_IDLE;
      default:  vpa_state_d = VPA_IDLE;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      int_en_q      <= 1'b0;
      pending_q     <= 1'b0;
      vpa_state_q   <= VPA_IDLE;
      frame_start_q <= 1'b0;
    end else begin
      int_en_q      <= int_en_d;
      pending_q     <= pending_d;
      vpa_state_q   <= vpa_state_d;
      frame_start_q <= vbl_rise;
    end
  end

  // Status read word: vblank in its bit position, zero when not selected.
  always_comb begin
    rd_data = '0;
    if (bus.vblank_cs && bus.cpu_rw) rd_data[VBL_BIT] = vblank_q;
  end

  assign bus.irq_dout  = rd_data;
  assign bus.vpa_n     = (vpa_state_q != VPA_ACK);
  assign ipl_n         = pending_q ? ~LEVEL : IPL_NONE;
  assign int_en        = int_en_q;
  assign frame_start   = frame_start_q;
  assign dbg_vpa_state = vpa_state_q;

  // Only bit 0 of the write data is meaningful for the enable register.
  assign unused_dout = ^bus.cpu_dout[15:1];

endmodule

// File: tb/tb_m68k_irq_ctrl.sv
// Directed bench for m68k_irq_ctrl (IRQ_LEVEL 4, vblank in status bit 0).
module tb_m68k_irq_ctrl;
  import irq_pkg::*;

  logic       clk_sys;
  logic       reset;
  logic       vblank;
  logic [2:0] ipl_n;
  logic       int_en;
  logic       frame_start;
  vpa_state_e dbg_vpa_state;

  int checks = 0;
  int errors = 0;

  m68k_irq_ctrl_if bus ();

  m68k_irq_ctrl #(.IRQ_LEVEL(4), .VBL_BIT(0)) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .vblank        (vblank),
    .bus           (bus),
    .ipl_n         (ipl_n),
    .int_en        (int_en),
    .frame_start   (frame_start),
    .dbg_vpa_state (dbg_vpa_state)
  );

  // Clock and reset generation.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Advance past one rising edge; outputs are sampled 2 ns later.
  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    bus.int_en_cs = 1'b0;
    bus.vblank_cs = 1'b0;
    bus.cpu_rw    = 1'b1;
    bus.cpu_lds_n = 1'b1;
    bus.cpu_as_n  = 1'b1;
    bus.cpu_fc    = 3'b000;
    bus.cpu_a     = 3'b000;
    bus.cpu_dout  = 16'h0000;
  endtask

  task automatic write_en(input logic [15:0] data);
    bus.int_en_cs = 1'b1;
    bus.cpu_rw    = 1'b0;
    bus.cpu_lds_n = 1'b0;
    bus.cpu_as_n  = 1'b0;
    bus.cpu_dout  = data;
  endtask

  task automatic iack_start(input logic [2:0] level);
    bus.cpu_fc   = FC_IACK;
    bus.cpu_a    = level;
    bus.cpu_as_n = 1'b0;
  endtask

  initial begin
    bus_idle();
    vblank = 1'b0;
    reset  = 1'b1;
    tick();
    tick();
    chk("rst_ipl_n", 16'(ipl_n), 16'(3'b111));
    chk("rst_vpa_n", 16'(bus.vpa_n), 16'd1);
    chk("rst_int_en", 16'(int_en), 16'd0);
    chk("rst_frame_start", 16'(frame_start), 16'd0);
    chk("rst_irq_dout", bus.irq_dout, 16'h0000);
    reset = 1'b0;
    tick();

    // Vblank rise with interrupts disabled: pulse only.
    vblank = 1'b1;
    tick();
    chk("dis_rise_frame_start", 16'(frame_start), 16'd1);
    chk("dis_rise_ipl_n", 16'(ipl_n), 16'(3'b111));
    tick();
    chk("dis_rise_pulse_end", 16'(frame_start), 16'd0);
    vblank = 1'b0;
    tick();

    // Enable, then vblank rise raises level 4.
    write_en(16'h0001);
    tick();
    chk("en_write_int_en", 16'(int_en), 16'd1);
    bus_idle();
    vblank = 1'b1;
    tick();
    chk("en_rise_ipl_n", 16'(ipl_n), 16'(3'b011));
    chk("en_rise_frame_start", 16'(frame_start), 16'd1);

    // Status read during and outside vblank.
    bus.vblank_cs = 1'b1;
    #1;
    chk("status_in_vblank", bus.irq_dout, 16'h0001);
    bus.vblank_cs = 1'b0;
    #1;
    chk("status_unselected", bus.irq_dout, 16'h0000);

    // IACK at level 4: autovector, pending cleared, VPA released with AS.
    iack_start(3'd4);
    tick();
    chk("iack4_vpa_n", 16'(bus.vpa_n), 16'd0);
    chk("iack4_ipl_n", 16'(ipl_n), 16'(3'b111));
    tick();
    chk("iack4_vpa_hold", 16'(bus.vpa_n), 16'd0);
    bus_idle();
    tick();
    chk("iack4_vpa_release", 16'(bus.vpa_n), 16'd1);

    // Pending then disable write: request dropped, later IACK ignored.
    vblank = 1'b0;
    tick();
    bus.vblank_cs = 1'b1;
    #1;
    chk("status_out_vblank", bus.irq_dout, 16'h0000);
    bus.vblank_cs = 1'b0;
    vblank = 1'b1;
    tick();
    chk("pend2_ipl_n", 16'(ipl_n), 16'(3'b011));
    write_en(16'h0000);
    tick();
    chk("disable_ipl_n", 16'(ipl_n), 16'(3'b111));
    chk("disable_int_en", 16'(int_en), 16'd0);
    bus_idle();
    iack_start(3'd4);
    tick();
    chk("disabled_iack_vpa_n", 16'(bus.vpa_n), 16'd1);
    bus_idle();
    tick();

    // Re-enable, raise a request, IACK at the wrong level is ignored.
    write_en(16'h0001);
    tick();
    bus_idle();
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    chk("pend3_ipl_n", 16'(ipl_n), 16'(3'b011));
    iack_start(3'd2);
    tick();
    chk("iack2_vpa_n", 16'(bus.vpa_n), 16'd1);
    chk("iack2_ipl_n", 16'(ipl_n), 16'(3'b011));
    bus_idle();
    tick();

    // New frame coincident with acceptance: vpa_n low, request stays.
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    iack_start(3'd4);
    tick();
    chk("coinc_vpa_n", 16'(bus.vpa_n), 16'd0);
    chk("coinc_ipl_n", 16'(ipl_n), 16'(3'b011));
    bus_idle();
    tick();
    chk("coinc_vpa_release", 16'(bus.vpa_n), 16'd1);
    chk("coinc_ipl_after", 16'(ipl_n), 16'(3'b011));

    // Accept the remaining request, then a new frame while VPA is still low.
    iack_start(3'd4);
    tick();
    chk("mid_vpa_n", 16'(bus.vpa_n), 16'd0);
    chk("mid_ipl_n", 16'(ipl_n), 16'(3'b111));
    vblank = 1'b0;
    tick();
    vblank = 1'b1;
    tick();
    chk("pre_rst_vpa_n", 16'(bus.vpa_n), 16'd0);
    chk("pre_rst_ipl_n", 16'(ipl_n), 16'(3'b011));

    // Reset mid-IACK with a request pending and vblank high.
    reset = 1'b1;
    bus.vblank_cs = 1'b1;
    tick();
    chk("midrst_ipl_n", 16'(ipl_n), 16'(3'b111));
    chk("midrst_vpa_n", 16'(bus.vpa_n), 16'd1);
    chk("midrst_int_en", 16'(int_en), 16'd0);
    chk("midrst_frame_start", 16'(frame_start), 16'd0);
    chk("midrst_irq_dout", bus.irq_dout, 16'h0000);
    bus_idle();

    // Release reset with vblank held high: no frame pulse.
    reset = 1'b0;
    tick();
    chk("held_vbl_fs_0", 16'(frame_start), 16'd0);
    tick();
    chk("held_vbl_fs_1", 16'(frame_start), 16'd0);
    tick();
    chk("held_vbl_fs_2", 16'(frame_start), 16'd0);
    chk("held_vbl_ipl_n", 16'(ipl_n), 16'(3'b111));
    bus.vblank_cs = 1'b1;
    #1;
    chk("held_vbl_status", bus.irq_dout, 16'h0001);
    bus_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
